vect_accum_wb: RTL and testbench

- Writeback/accumulate stage directly downstream of the vector ALU in the SIMD FIR datapath.
- Sums per-lane ALU products over a programmable number of taps into wide saturating accumulators.
- Scales each sum by an arithmetic right shift, saturates it back to N bits, and presents the vector for writeback with a valid/ready handshake.

---
 rtl/vect_accum_wb.sv | 181 ++++++++++++++++++
 tb/tb_vect_accum_wb.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/vect_accum_wb.sv
// Vector accumulate/writeback stage: per-lane saturating tap accumulation, shift-and-clip scaling, valid/ready output.
// Optional feature: define VACC_ROUND_EN for round-half-up before the output shift (default: truncation toward -inf).
module vect_accum_wb #(
  parameter int N      = 8,
  parameter int M      = 4,
  parameter int ACC_W  = 16,
  parameter int TAPS_W = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  clear,
  input  logic [TAPS_W-1:0]     tap_count,
  input  logic [3:0]            shamt,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [M-1:0][N-1:0]   alu_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [M-1:0][N-1:0]   out_data,
  output logic [M-1:0]          sat_flags
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_OUT   = 2'd2;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [N-1:0]     OUT_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]     OUT_MIN = {1'b1, {(N-1){1'b0}}};

`ifdef VACC_ROUND_EN
  // Wide enough that adding the largest rounding constant can never wrap.
  localparam int RND_W = ACC_W + 17;
`endif

  // Returns {overflowed, saturated sum} of two ACC_W-bit signed values.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (s[ACC_W] != s[ACC_W-1]) return {1'b1, (s[ACC_W] ? ACC_MIN : ACC_MAX)};
    return {1'b0, s[ACC_W-1:0]};
  endfunction

  // Returns {clipped, N-bit result} of the optional rounding, arithmetic shift and signed clip.
  function automatic logic [N:0] scale(input logic [ACC_W-1:0] acc,
                                       input logic [3:0]       sh);
    logic [ACC_W-1:0] a;
    logic [ACC_W-1:0] s;
`ifdef VACC_ROUND_EN
    logic [RND_W-1:0] wide;
`endif
    a = acc;
`ifdef VACC_ROUND_EN
    if (sh != 4'd0) begin
      wide = {{(RND_W-ACC_W){acc[ACC_W-1]}}, acc} + (RND_W'(1) << (sh - 4'd1));
      // The rounding constant is positive, so only the upper limit can be hit.
      if (!wide[RND_W-1] && (|wide[RND_W-2:ACC_W-1])) a = ACC_MAX;
      else a = wide[ACC_W-1:0];
    end
`endif
    s = $signed(a) >>> sh;
    if ((s[ACC_W-1:N-1] == '0) || (s[ACC_W-1:N-1] == '1)) return {1'b0, s[N-1:0]};
    return {1'b1, (s[ACC_W-1] ? OUT_MIN : OUT_MAX)};
  endfunction

  logic [1:0]                 state_q, state_d;
  logic [TAPS_W-1:0]          taps_q, taps_d;
  logic [TAPS_W-1:0]          cnt_q, cnt_d;
  logic [3:0]                 shamt_q, shamt_d;
  logic [M-1:0][ACC_W-1:0]    acc_q, acc_d;
  logic [M-1:0]               ovf_q, ovf_d;
  logic [M-1:0][N-1:0]        out_data_q, out_data_d;
  logic [M-1:0]               sat_q, sat_d;
  logic                       out_valid_q, out_valid_d;
  logic                       go_out;
  logic [ACC_W:0]             add_res;
  logic [N:0]                 scl_res;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    taps_d      = taps_q;
    cnt_d       = cnt_q;
    shamt_d     = shamt_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_data_d  = out_data_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    go_out      = 1'b0;
    add_res     = '0;
    scl_res     = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          taps_d  = tap_count;
          shamt_d = shamt;
          cnt_d   = '0;
          acc_d   = '0;
          ovf_d   = '0;
          if (tap_count == '0) go_out = 1'b1;
          else state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (in_valid) begin
          for (int i = 0; i < M; i++) begin
            add_res  = sat_add(acc_q[i], {{(ACC_W-N){alu_result[i][N-1]}}, alu_result[i]});
            acc_d[i] = add_res[ACC_W-1:0];
            ovf_d[i] = ovf_q[i] | add_res[ACC_W];
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == taps_q - 1'b1) go_out = 1'b1;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Scale from the post-beat accumulator so the result is ready the cycle after the last beat.
    if (go_out) begin
      for (int i = 0; i < M; i++) begin
        scl_res       = scale(acc_d[i], shamt_d);
        out_data_d[i] = scl_res[N-1:0];
        sat_d[i]      = scl_res[N] | ovf_d[i];
      end
      out_valid_d = 1'b1;
      state_d     = S_OUT;
    end

    if (clear) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      acc_d       = '0;
      ovf_d       = '0;
      sat_d       = '0;
      out_valid_d = 1'b0;
    end
  end

  // NOTE: the accumulators are plain flops, not a RAM, so they take the async reset like the rest of the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      taps_q      <= '0;
      cnt_q       <= '0;
      shamt_q     <= '0;
      acc_q       <= '0;
      ovf_q       <= '0;
      out_data_q  <= '0;
      sat_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge values of the others.
      state_q     <= state_d;
      taps_q      <= taps_d;
      cnt_q       <= cnt_d;
      shamt_q     <= shamt_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_data_q  <= out_data_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_ACCUM);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sat_flags = sat_q;

endmodule

// File: tb/tb_vect_accum_wb.sv
// Randomized self-checking bench for vect_accum_wb: two instances (ACC_W=16 and ACC_W=12) share stimulus
// and are compared against an integer reference model of the accumulate/scale/clip rules.
module tb_vect_accum_wb;
  localparam int N = 8;
  localparam int M = 4;
  localparam int TAPS_W = 6;

  typedef logic [M-1:0][N-1:0] vec_t;

  logic clk = 1'b0;
  logic rst_n, start, clear, in_valid, out_ready;
  logic [TAPS_W-1:0] tap_count;
  logic [3:0] shamt;
  vec_t alu_result;
  logic in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  vec_t out_data_a, out_data_b;
  logic [M-1:0] sat_flags_a, sat_flags_b;

  int n_checks = 0;
  int n_fail = 0;
  vec_t beats_q[$];

  always #5 clk = ~clk;

  vect_accum_wb #(.N(N), .M(M), .ACC_W(16), .TAPS_W(TAPS_W)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .tap_count(tap_count),
    .shamt(shamt), .in_valid(in_valid), .in_ready(in_ready_a), .alu_result(alu_result),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a), .sat_flags(sat_flags_a));

  vect_accum_wb #(.N(N), .M(M), .ACC_W(12), .TAPS_W(TAPS_W)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .tap_count(tap_count),
    .shamt(shamt), .in_valid(in_valid), .in_ready(in_ready_b), .alu_result(alu_result),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b), .sat_flags(sat_flags_b));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < M; i++) v[i] = N'($urandom);
    return v;
  endfunction

  // Reference: sum the accepted beats with clamping, optionally round, shift, clip.
  function automatic void model(input int acc_w, input int sh, output vec_t d, output logic [M-1:0] f);
    int hi, lo, acc, r;
    bit ovf, clip;
    hi = (1 << (acc_w - 1)) - 1;
    lo = -(1 << (acc_w - 1));
    for (int i = 0; i < M; i++) begin
      acc = 0;
      ovf = 0;
      foreach (beats_q[b]) begin
        acc = acc + int'($signed(beats_q[b][i]));
        if (acc > hi) begin acc = hi; ovf = 1; end
        if (acc < lo) begin acc = lo; ovf = 1; end
      end
`ifdef VACC_ROUND_EN
      if (sh > 0) begin
        acc = acc + (1 << (sh - 1));
        if (acc > hi) acc = hi;
      end
`endif
      r = acc >>> sh;
      clip = 0;
      if (r > 127) begin r = 127; clip = 1; end
      if (r < -128) begin r = -128; clip = 1; end
      d[i] = N'(r);
      f[i] = ovf | clip;
    end
  endfunction

  task automatic check_out(input string tag, input vec_t ea, input logic [M-1:0] fa,
                           input vec_t eb, input logic [M-1:0] fb, input logic exp_valid);
    check({tag, "_valid_a"}, out_valid_a, exp_valid);
    check({tag, "_valid_b"}, out_valid_b, exp_valid);
    check({tag, "_data_a"}, out_data_a, ea);
    check({tag, "_data_b"}, out_data_b, eb);
    check({tag, "_flags_a"}, sat_flags_a, fa);
    check({tag, "_flags_b"}, sat_flags_b, fb);
  endtask

  // One complete transaction. vmode: 0 always valid, 1 alternating, 2 random.
  task automatic run_txn(input string tag, input int taps, input int sh, input bit fixed,
                         input vec_t fvec, input int vmode, input int hold);
    int cyc;
    vec_t v, ea, eb;
    logic [M-1:0] fa, fb;
    beats_q.delete();
    start = 1'b1;
    tap_count = TAPS_W'(taps);
    shamt = 4'(sh);
    tick();
    start = 1'b0;
    tap_count = TAPS_W'($urandom);
    shamt = 4'($urandom);
    cyc = 0;
    while (taps > 0 && beats_q.size() < taps && cyc < 200) begin
      check({tag, "_in_ready_a"}, in_ready_a, 1'b1);
      check({tag, "_in_ready_b"}, in_ready_b, 1'b1);
      check({tag, "_busy_valid"}, out_valid_a, 1'b0);
      v = fixed ? fvec : rand_vec();
      alu_result = v;
      in_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      if (in_valid) beats_q.push_back(v);
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    alu_result = rand_vec();
    if (taps > 0 && beats_q.size() < taps) check({tag, "_beat_budget"}, 64'(beats_q.size()), 64'(taps));
    model(16, sh, ea, fa);
    model(12, sh, eb, fb);
    check_out({tag, "_out"}, ea, fa, eb, fb, 1'b1);
    check({tag, "_out_in_ready"}, in_ready_a, 1'b0);
    for (int h = 0; h < hold; h++) begin
      start = 1'b1;
      in_valid = 1'b1;
      tick();
      check_out({tag, "_hold"}, ea, fa, eb, fb, 1'b1);
      check({tag, "_hold_in_ready"}, in_ready_a | in_ready_b, 1'b0);
    end
    start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_out({tag, "_done"}, ea, fa, eb, fb, 1'b0);
    tick();
    check({tag, "_idle_in_ready"}, in_ready_a | in_ready_b, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    vec_t fv, exp_lit;
    logic [M-1:0] exp_flags;
    rst_n = 1'b0; start = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tap_count = '0; shamt = '0; alu_result = '0;
    repeat (3) tick();
    check("rst_in_ready", in_ready_a | in_ready_b, 1'b0);
    check_out("rst", '0, '0, '0, '0, 1'b0);
    rst_n = 1'b1;
    tick();

    // Directed: three beats of {10,-5,127,-128}.
    fv[0] = 8'd10; fv[1] = 8'hFB; fv[2] = 8'h7F; fv[3] = 8'h80;
    run_txn("t1", 3, 0, 1'b1, fv, 0, 2);
    exp_lit = {8'h80, 8'h7F, 8'hF1, 8'h1E};
    check("t1_lit_data", out_data_a, exp_lit);
    check("t1_lit_flags", sat_flags_a, 4'b1100);

    run_txn("t2", 3, 2, 1'b1, fv, 0, 0);
`ifdef VACC_ROUND_EN
    exp_lit = {8'hA0, 8'h5F, 8'hFC, 8'h08};
`else
    exp_lit = {8'hA0, 8'h5F, 8'hFC, 8'h07};
`endif
    check("t2_lit_data", out_data_a, exp_lit);
    check("t2_lit_flags", sat_flags_a, 4'b0000);

    // Lane0 = 127 for 17 beats: dut_b accumulator clamps at 2047.
    fv = '0;
    fv[0] = 8'h7F;
    run_txn("t3", 17, 0, 1'b1, fv, 0, 0);
    check("t3_lit_data_b", out_data_b[0], 8'h7F);
    check("t3_lit_flag_b", sat_flags_b[0], 1'b1);

    run_txn("t4", 4, 1, 1'b0, fv, 1, 5);
    run_txn("t5", 0, 3, 1'b0, fv, 0, 1);
    check("t5_lit_data", out_data_a, 32'h0);

    // Clear after 2 of 4 beats, with a beat offered on the same cycle.
    start = 1'b1; tap_count = 6'd4; shamt = 4'd0;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    repeat (2) begin alu_result = rand_vec(); tick(); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    in_valid = 1'b0;
    check("clr_in_ready", in_ready_a | in_ready_b, 1'b0);
    check("clr_valid", out_valid_a | out_valid_b, 1'b0);
    check("clr_flags", sat_flags_a | sat_flags_b, 4'b0000);
    repeat (3) begin tick(); check("clr_quiet", out_valid_a | out_valid_b | in_ready_a, 1'b0); end
    // Clear beats a simultaneous start.
    start = 1'b1; clear = 1'b1; tap_count = 6'd2;
    tick();
    start = 1'b0; clear = 1'b0;
    check("clr_vs_start", in_ready_a | in_ready_b, 1'b0);
    fv[0] = 8'd1; fv[1] = 8'd2; fv[2] = 8'd3; fv[3] = 8'd4;
    run_txn("t6", 1, 0, 1'b1, fv, 0, 0);
    check("t6_lit_data", out_data_a, {8'd4, 8'd3, 8'd2, 8'd1});
    check("t6_lit_data_b", out_data_b, {8'd4, 8'd3, 8'd2, 8'd1});

    // Async reset in the middle of an accumulation.
    start = 1'b1; tap_count = 6'd5;
    tick();
    start = 1'b0;
    in_valid = 1'b1; alu_result = rand_vec();
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_mid_in_ready", in_ready_a | in_ready_b, 1'b0);
    tick();
    rst_n = 1'b1;
    check("rst_mid_valid", out_valid_a | out_valid_b, 1'b0);
    tick();
    run_txn("t7", 1, 0, 1'b1, fv, 0, 0);
    check("t7_lit_data", out_data_a, {8'd4, 8'd3, 8'd2, 8'd1});

    for (int k = 0; k < 30; k++)
      run_txn("rnd", $urandom_range(0, 20), $urandom_range(0, 15), 1'b0, fv,
              $urandom_range(0, 2), $urandom_range(0, 3));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
